// File: rtl/dis_table_loader.sv
// dis_table_loader: unpacks a 64-bit packed-distance stream into one
// two-point distance table write per cycle, walking the N x N matrix in
// row-major order (diagonal included).
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   start, city_count       begin a load of city_count x city_count entries
//   abort                   cancel a load in progress
//   s_valid/s_ready/s_data  input word handshake, lane 0 consumed first
//   tp_dis_write/waddr/wdata table write broadcast, waddr = {row, column}
//   busy, done, error       host status (busy in LOAD, done/error pulses)
module dis_table_loader #(
    parameter int unsigned CITY_NUM_LOG = 7,
    parameter int unsigned DIS_W        = 16,
    parameter int unsigned LANES        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CITY_NUM_LOG:0]     city_count,
    input  logic                      abort,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [63:0]               s_data,
    output logic                      tp_dis_write,
    output logic [2*CITY_NUM_LOG-1:0] tp_dis_waddr,
    output logic [DIS_W-1:0]          tp_dis_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int unsigned CNT_W  = CITY_NUM_LOG + 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0]  N_MIN     = CNT_W'(2);
    localparam logic [CNT_W-1:0]  N_MAX     = CNT_W'(1) << CITY_NUM_LOG;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                    state, state_d;
    logic [CNT_W-1:0]          n_q, n_d;
    logic [CITY_NUM_LOG-1:0]   i_q, i_d, j_q, j_d;
    logic [63:0]               buf_q, buf_d;
    logic                      buf_valid, buf_valid_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic                      write_d, busy_d, done_d, error_d;
    logic [2*CITY_NUM_LOG-1:0] waddr_d;
    logic [DIS_W-1:0]          wdata_d;

    logic [CNT_W-1:0] n_m1;
    logic             legal_n;
    logic             row_end;
    logic             last_entry;
    logic             consume;
    logic             accept;

    assign n_m1       = n_q - CNT_W'(1);
    assign legal_n    = (city_count >= N_MIN) && (city_count <= N_MAX);
    assign row_end    = (CNT_W'(j_q) == n_m1);
    assign last_entry = row_end && (CNT_W'(i_q) == n_m1);
    assign consume    = (state == S_LOAD) && !abort && buf_valid;

    // Refill either into an empty buffer or on its final lane, so the next
    // word lands exactly when the current one runs out; never after the last entry.
    assign s_ready = (state == S_LOAD) &&
                     (!buf_valid || (lane_q == LANE_LAST && !last_entry));
    assign accept  = s_valid && s_ready;

    // State and datapath register
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            n_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            buf_q        <= '0;
            buf_valid    <= 1'b0;
            lane_q       <= '0;
            tp_dis_write <= 1'b0;
            tp_dis_waddr <= '0;
            tp_dis_wdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_d;
            n_q          <= n_d;
            i_q          <= i_d;
            j_q          <= j_d;
            buf_q        <= buf_d;
            buf_valid    <= buf_valid_d;
            lane_q       <= lane_d;
            tp_dis_write <= write_d;
            tp_dis_waddr <= waddr_d;
            tp_dis_wdata <= wdata_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start && !abort && legal_n) state_d = S_LOAD;
            S_LOAD: begin
                if (abort)                      state_d = S_IDLE;
                else if (consume && last_entry) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid;
        lane_d      = lane_q;
        write_d     = 1'b0;
        waddr_d     = tp_dis_waddr;
        wdata_d     = tp_dis_wdata;
        error_d     = 1'b0;
        busy_d      = (state_d == S_LOAD);
        done_d      = (state_d == S_DONE);

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (legal_n) begin
                        n_d         = city_count;
                        i_d         = '0;
                        j_d         = '0;
                        buf_valid_d = 1'b0;
                        lane_d      = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    buf_valid_d = 1'b0;
                    lane_d      = '0;
                end else begin
                    if (consume) begin
                        write_d = 1'b1;
                        waddr_d = {i_q, j_q};
                        wdata_d = buf_q[DIS_W*32'(lane_q) +: DIS_W];
                        lane_d  = lane_q + LANE_W'(1);
                        if (last_entry) begin
                            i_d = '0;
                            j_d = '0;
                        end else if (row_end) begin
                            j_d = '0;
                            i_d = i_q + CITY_NUM_LOG'(1);
                        end else begin
                            j_d = j_q + CITY_NUM_LOG'(1);
                        end
                        // Unconsumed lanes of the final word are dropped.
                        if (lane_q == LANE_LAST || last_entry) begin
                            buf_valid_d = 1'b0;
                            lane_d      = '0;
                        end
                    end
                    if (accept) begin
                        buf_d       = s_data;
                        buf_valid_d = 1'b1;
                        lane_d      = '0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dis_table_loader.sv
module tb_dis_table_loader;

    logic        clk = 1'b0;
    logic        reset, start, abort, s_valid, s_ready;
    logic [7:0]  city_count;
    logic [63:0] s_data;
    logic        tp_dis_write, busy, done, error;
    logic [13:0] tp_dis_waddr;
    logic [15:0] tp_dis_wdata;

    int total = 0;
    int bad   = 0;

    dis_table_loader #(.CITY_NUM_LOG(7), .DIS_W(16), .LANES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .city_count(city_count),
        .abort(abort), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .tp_dis_write(tp_dis_write), .tp_dis_waddr(tp_dis_waddr),
        .tp_dis_wdata(tp_dis_wdata), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the table is a flat sequence of N*N entries; entry e
    // belongs at row e/N, column e%N. Accepted words enqueue their entries,
    // and one queued entry is written per cycle.
    typedef struct {
        int          idx;
        logic [13:0] addr;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_load = 0, m_done = 0, m_err = 0, m_write = 0;
    logic [13:0] m_addr = '0;
    logic [15:0] m_data = '0;
    int          m_n = 0, m_acc = 0;

    int          wr_cnt = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0;
    logic [13:0] wlog_addr[$];
    logic [15:0] wlog_data[$];

    function automatic logic [13:0] addr_of(input int e, input int n);
        return 14'((e / n) * 128 + (e % n));
    endfunction

    always @(negedge clk) begin
        bit   m_ready, hs, n_write, n_done, n_err;
        ent_t ent;
        int   nn;
        nn      = m_n * m_n;
        m_ready = m_load && (q.size() == 0 || (q.size() == 1 && q[0].idx != nn - 1));

        check("tp_dis_write", tp_dis_write, m_write);
        if (m_write) begin
            check("tp_dis_waddr", tp_dis_waddr, m_addr);
            check("tp_dis_wdata", tp_dis_wdata, m_data);
        end
        check("busy", busy, m_load);
        check("done", done, m_done);
        check("error", error, m_err);
        check("s_ready", s_ready, m_ready);

        if (tp_dis_write) begin
            wr_cnt++;
            wlog_addr.push_back(tp_dis_waddr);
            wlog_data.push_back(tp_dis_wdata);
        end
        if (done)  done_cnt++;
        if (error) err_cnt++;
        if (s_valid && s_ready) hs_cnt++;

        hs      = s_valid && m_ready;
        n_write = 0;
        n_done  = 0;
        n_err   = 0;
        if (reset) begin
            m_load = 0;
            q.delete();
            m_addr = '0;
            m_data = '0;
        end else if (m_load) begin
            if (abort) begin
                m_load = 0;
                q.delete();
            end else begin
                if (q.size() > 0) begin
                    ent     = q.pop_front();
                    n_write = 1;
                    m_addr  = ent.addr;
                    m_data  = ent.data;
                    if (ent.idx == nn - 1) begin
                        m_load = 0;
                        n_done = 1;
                        q.delete();
                    end
                end
                if (hs) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_acc < nn) begin
                            ent.idx  = m_acc;
                            ent.addr = addr_of(m_acc, m_n);
                            ent.data = s_data[k*16 +: 16];
                            q.push_back(ent);
                            m_acc++;
                        end
                    end
                end
            end
        end else if (!m_done && start && !abort) begin
            if (city_count >= 2 && city_count <= 128) begin
                m_load = 1;
                m_n    = int'(city_count);
                m_acc  = 0;
                q.delete();
            end else begin
                n_err = 1;
            end
        end
        m_write = n_write;
        m_done  = n_done;
        m_err   = n_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        city_count = 8'(n);
        tick();
        start      = 1'b0;
    endtask

    function automatic logic [63:0] make_word(input int e);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'((e + k) * 257 + 48);
        return w;
    endfunction

    task automatic send_word(input logic [63:0] w, output bit ok);
        bit hs;
        ok      = 0;
        s_valid = 1'b1;
        s_data  = w;
        for (int b = 0; b < 200; b++) begin
            @(negedge clk);
            hs = s_ready;
            tick();
            if (hs) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int b = 0; b < 2000; b++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        tick();
    endtask

    task automatic stream(input int n, input int gap_after, input int gap_len);
        int words;
        bit ok;
        words = (n * n + 3) / 4;
        for (int w = 0; w < words; w++) begin
            send_word(make_word(w * 4), ok);
            check("handshake_timeout", ok, 1);
            if (w == gap_after) begin
                s_valid = 1'b0;
                repeat (gap_len) tick();
            end
        end
        s_valid = 1'b0;
        wait_idle(ok);
        check("idle_timeout", ok, 1);
        repeat (2) tick();
    endtask

    task automatic run_n2_literal();
        bit ok;
        int d0;
        wlog_addr.delete();
        wlog_data.delete();
        d0 = done_cnt;
        do_start(2);
        send_word(64'h0004_0003_0002_0001, ok);
        check("n2_handshake", ok, 1);
        s_valid = 1'b0;
        wait_idle(ok);
        check("n2_idle", ok, 1);
        repeat (3) tick();
        check("n2_writes", wlog_addr.size(), 4);
        if (wlog_addr.size() == 4) begin
            check("n2_a0", wlog_addr[0], 14'h000); check("n2_d0", wlog_data[0], 16'd1);
            check("n2_a1", wlog_addr[1], 14'h001); check("n2_d1", wlog_data[1], 16'd2);
            check("n2_a2", wlog_addr[2], 14'h080); check("n2_d2", wlog_data[2], 16'd3);
            check("n2_a3", wlog_addr[3], 14'h081); check("n2_d3", wlog_data[3], 16'd4);
        end
        check("n2_done_pulses", done_cnt - d0, 1);
        check("n2_s_ready_after", s_ready, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_hs, b_err, b_done, wr_a, e;
        bit hs, hit;

        reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        s_data = '0; city_count = '0;
        repeat (3) tick();
        check("rst_write", tp_dis_write, 0);
        check("rst_waddr", tp_dis_waddr, 0);
        check("rst_wdata", tp_dis_wdata, 0);
        check("rst_status", {busy, done, error, s_ready}, 4'b0000);
        reset = 1'b0;
        tick();

        // N=2 single word, hand-computed writes
        run_n2_literal();

        // N=3, continuous stream
        b_wr = wr_cnt; b_hs = hs_cnt;
        wlog_addr.delete();
        do_start(3);
        stream(3, -1, 0);
        check("n3_handshakes", hs_cnt - b_hs, 3);
        check("n3_writes", wr_cnt - b_wr, 9);
        if (wlog_addr.size() == 9) begin
            check("n3_first_addr", wlog_addr[0], 14'h000);
            check("n3_row1_addr", wlog_addr[3], 14'h080);
            check("n3_last_addr", wlog_addr[8], 14'h102);
        end

        // N=4 with an input gap between words 2 and 3
        b_wr = wr_cnt;
        do_start(4);
        stream(4, 1, 5);
        check("n4_writes", wr_cnt - b_wr, 16);

        // Illegal city counts, and start coincident with abort
        b_wr = wr_cnt; b_err = err_cnt;
        do_start(1);
        repeat (2) tick();
        do_start(129);
        repeat (2) tick();
        start = 1'b1; abort = 1'b1; city_count = 8'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (2) tick();
        check("err_pulses", err_cnt - b_err, 2);
        check("err_no_writes", wr_cnt - b_wr, 0);
        check("err_idle", {busy, s_ready}, 2'b00);

        // N=128 aborted after about 10 writes, then a clean N=2 load
        b_wr = wr_cnt; b_done = done_cnt;
        do_start(128);
        e = 0;
        s_valid = 1'b1;
        s_data  = make_word(0);
        hit     = 0;
        for (int b = 0; b < 100 && !hit; b++) begin
            @(negedge clk);
            hs  = s_ready;
            hit = (wr_cnt - b_wr >= 10);
            tick();
            if (hs) begin
                e += 4;
                s_data = make_word(e);
            end
        end
        check("abort_reached_10", hit, 1);
        abort = 1'b1; s_valid = 1'b0;
        tick();
        abort = 1'b0;
        tick();
        wr_a = wr_cnt;
        repeat (5) tick();
        check("abort_writes_stopped", wr_cnt, wr_a);
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_busy", busy, 0);
        run_n2_literal();

        // Reset in the middle of an N=5 load
        do_start(5);
        send_word(make_word(0), hit);
        send_word(make_word(4), hit);
        s_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_outputs", {tp_dis_write, busy, done, error, s_ready}, 5'b00000);
        check("midrst_waddr", tp_dis_waddr, 0);
        reset = 1'b0;
        tick();
        run_n2_literal();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
